amo_sequencer: RTL and testbench
================================

AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high; these are the first two ports.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  core clock
- reset  in  1  synchronous reset, active-high
- start_i  in  1  start request; sampled only in IDLE
- kind_i  in  2  amo_kind_e: LR, SC or RMW
- op_i  in  10  iTypeAtomic_e one-hot; meaningful only for RMW
- addr_i  in  32  word address
- data_i  in  32  rs2 operand
- clear_rsv_i  in  1  trap/xRET; invalidates the reservation
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- result_o  out  32  value for rd
- misaligned_o  out  1  pulses with done_o when addr_i[1:0] != 0
- illegal_o  out  1  pulses with done_o when RMW has op_i == AMONOP or op_i is not one-hot
- mem_req_o  out  1  memory request
- mem_we_o  out  4  byte write enables; 0000 for reads
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rdata_i  in  32  read data, valid the cycle after a granted read

Function
REQ-003 The FSM states SHALL be IDLE, READ, RDATA, WRITE and DONE.
REQ-004 In IDLE with start_i=1, the block SHALL latch kind, op, addr and data, then move as follows:
- misaligned or illegal: DONE, no memory access
- LR or RMW: READ
- SC with a valid reservation and rsv_addr==addr_i: WRITE
- any other SC: DONE with result 1
REQ-005 In READ the block SHALL drive mem_req_o=1, mem_we_o=0000 and mem_addr_o=latched addr, and SHALL hold those values until mem_gnt_i=1, then go to RDATA.
REQ-006 In RDATA the block SHALL capture mem_rdata_i as old, then go to DONE for LR or to WRITE for RMW.
REQ-007 For LR, the block SHALL set reservation valid with rsv_addr=addr, and result_o=old.
REQ-008 In WRITE the block SHALL drive mem_req_o=1, mem_we_o=1111 and mem_wdata_o equal to:
- RMW: amo_alu(op, old, data)
- SC: data
It SHALL hold those values until mem_gnt_i=1, then go to DONE.
REQ-009 For RMW, result_o SHALL be old; for a successful SC, result_o SHALL be 0.
REQ-010 The amo_alu function SHALL be defined per op:
- SWAP: b
- ADD: a+b modulo 2^32
- XOR, AND, OR: the bitwise operation
- MIN, MAX: signed compare
- MINU, MAXU: unsigned compare
REQ-011 DONE SHALL last exactly one cycle with done_o=1 and result_o valid, and SHALL return to IDLE.
REQ-012 result_o SHALL hold its value until the next done_o.
REQ-013 Latency from start_i to done_o, with mem_gnt_i held at 1, SHALL be:
- RMW: 4 cycles
- LR: 3 cycles
- successful SC: 2 cycles
- failed SC, misaligned or illegal: 1 cycle
Each cycle mem_gnt_i is low SHALL add one cycle.
REQ-014 start_i outside IDLE SHALL be ignored.
REQ-015 Every SC, whether it succeeds or fails, SHALL clear the reservation on its DONE cycle.
REQ-016 clear_rsv_i SHALL clear the reservation on the next edge in any state, and SHALL take priority over a simultaneous LR set.
REQ-017 mem_req_o SHALL be 0 in IDLE, DONE, RDATA and every other state not listed in REQ-005 and REQ-008.
REQ-018 An RMW SHALL leave the reservation unchanged.

Reset
REQ-019 On a reset edge, the block SHALL clear every output and internal register to 0 and the state to IDLE:
- state=IDLE
- busy_o=0, done_o=0, result_o=0, misaligned_o=0, illegal_o=0
- mem_req_o=0, mem_we_o=0000, mem_addr_o=0, mem_wdata_o=0
- reservation invalid, rsv_addr=0
REQ-020 A reset asserted mid-operation SHALL abandon the transaction: no done_o pulse, and mem_req_o=0 from the cycle after the reset edge.

Structure
REQ-021 The types amo_kind_e {AMO_KIND_LR, AMO_KIND_SC, AMO_KIND_RMW} and amo_states_e SHALL live in RS5_pkg, alongside the existing iTypeAtomic_e.
REQ-022 The combinational ALU SHALL be a separate sub-module, amo_alu, with inputs (op, a, b) and output result.

Verification
REQ-023 RMW AMOADD at addr 0x100, memory 0x7FFFFFFF, data 1, gnt=1: done_o on cycle 4, result_o=0x7FFFFFFF, write 0x80000000 with we=1111.
REQ-024 AMOMIN with old=0xFFFFFFFF, data=1 writes 0xFFFFFFFF; AMOMINU with the same operands writes 0x00000001.
REQ-025 LR at 0x200, then SC at 0x200 with data 0xAA: SC result 0, write 0xAA; a second SC at 0x200: result 1, no mem_req_o.
REQ-026 LR at 0x200, then clear_rsv_i pulse, then SC at 0x200: result 1, no write; separately, LR at 0x200 then SC at 0x204: result 1.
REQ-027 RMW at addr 0x102: misaligned_o=1 and done_o=1 one cycle later, with mem_req_o never asserted.
REQ-028 gnt held low for 3 cycles in READ: the request stays stable and done_o arrives at cycle 7.
REQ-029 reset asserted in WRITE: mem_req_o=0 from the next cycle, no done_o pulse, reservation invalid.

Source files
------------

// File: rtl/RS5_pkg.sv
// Shared core types: atomic op encoding plus the AMO sequencer's
// request kind and FSM state.
package RS5_pkg;

  typedef enum logic [9:0] {
    AMONOP  = 10'b00_0000_0001,
    AMOSWAP = 10'b00_0000_0010,
    AMOADD  = 10'b00_0000_0100,
    AMOXOR  = 10'b00_0000_1000,
    AMOAND  = 10'b00_0001_0000,
    AMOOR   = 10'b00_0010_0000,
    AMOMIN  = 10'b00_0100_0000,
    AMOMAX  = 10'b00_1000_0000,
    AMOMINU = 10'b01_0000_0000,
    AMOMAXU = 10'b10_0000_0000
  } iTypeAtomic_e;

  typedef enum logic [1:0] {
    AMO_KIND_LR  = 2'd0,
    AMO_KIND_SC  = 2'd1,
    AMO_KIND_RMW = 2'd2
  } amo_kind_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } amo_states_e;

  function automatic logic is_onehot(
    input logic [9:0] v
  );
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write operator for AMO instructions.
// a is the old memory word, b the rs2 operand.
module amo_alu
  import RS5_pkg::*;
(
  input  iTypeAtomic_e op,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  output logic [31:0]  result
);

  always_comb begin
    result = '0;
    case (op)
      AMOSWAP: result = b;
      AMOADD:  result = a + b;
      AMOXOR:  result = a ^ b;
      AMOAND:  result = a & b;
      AMOOR:   result = a | b;
      AMOMIN:  result = ($signed(a) < $signed(b)) ? a : b;
      AMOMAX:  result = ($signed(a) > $signed(b)) ? a : b;
      AMOMINU: result = (a < b) ? a : b;
      AMOMAXU: result = (a > b) ? a : b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Sequences LR / SC / AMO read-modify-write transactions over a
// single-port req/gnt memory and tracks the LR reservation.
module amo_sequencer
  import RS5_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  kind_i,
  input  logic [9:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        clear_rsv_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_rdata_i
);

  amo_states_e state_q, state_d;

  logic [1:0]  kind_q;
  logic [9:0]  op_q;
  logic [31:0] addr_q, data_q, old_q;
  logic [31:0] result_q, result_d;
  logic [31:0] alu_res;
  logic        mis_q, ill_q;
  logic        rsv_valid_q;
  logic [31:0] rsv_addr_q;

  logic start_mis, start_ill, sc_hit;

  assign start_mis = addr_i[1:0] != 2'b00;
  assign start_ill = (kind_i == AMO_KIND_RMW)
                   ? (op_i == AMONOP || !is_onehot(op_i))
                   : (kind_i == 2'b11);
  assign sc_hit = rsv_valid_q && (rsv_addr_q == addr_i);

  amo_alu u_alu (
    .op     (iTypeAtomic_e'(op_q)),
    .a      (old_q),
    .b      (data_q),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_mis || start_ill)
            state_d = DONE;
          else if (kind_i == AMO_KIND_SC)
            state_d = sc_hit ? WRITE : DONE;
          else
            state_d = READ;
        end
      end
      READ:  if (mem_gnt_i) state_d = RDATA;
      RDATA: state_d = (kind_q == AMO_KIND_LR) ? DONE : WRITE;
      WRITE: if (mem_gnt_i) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = state_q != IDLE;
    done_o       = state_q == DONE;
    misaligned_o = (state_q == DONE) && mis_q;
    illegal_o    = (state_q == DONE) && ill_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (state_q == READ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = addr_q;
    end else if (state_q == WRITE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 4'b1111;
      mem_addr_o  = addr_q;
      mem_wdata_o = (kind_q == AMO_KIND_RMW) ? alu_res : data_q;
    end
  end

  // Value that rd will see, computed on the edge that enters DONE.
  always_comb begin
    result_d = result_q;
    unique case (state_q)
      IDLE:  result_d = (!start_mis && !start_ill
                         && kind_i == AMO_KIND_SC) ? 32'd1 : 32'd0;
      RDATA: result_d = mem_rdata_i;
      WRITE: result_d = (kind_q == AMO_KIND_RMW) ? old_q : 32'd0;
      default: result_d = result_q;
    endcase
  end

  assign result_o = result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q      <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      old_q       <= '0;
      result_q    <= '0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        kind_q <= kind_i;
        op_q   <= op_i;
        addr_q <= addr_i;
        data_q <= data_i;
        mis_q  <= start_mis;
        ill_q  <= start_ill;
      end
      if (state_q == RDATA) old_q <= mem_rdata_i;
      if (state_d == DONE && state_q != DONE) result_q <= result_d;
      if (clear_rsv_i)
        rsv_valid_q <= 1'b0;
      else if (state_q == DONE && kind_q == AMO_KIND_SC)
        rsv_valid_q <= 1'b0;
      else if (state_q == RDATA && kind_q == AMO_KIND_LR) begin
        rsv_valid_q <= 1'b1;
        rsv_addr_q  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Vector table plus scoreboard bench for amo_sequencer, with hand
// sequences for reservation clearing and reset mid-transaction.
module tb_amo_sequencer;
  import RS5_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  kind_i;
  logic [9:0]  op_i;
  logic [31:0] addr_i, data_i;
  logic        clear_rsv_i;
  logic        busy_o, done_o, misaligned_o, illegal_o;
  logic [31:0] result_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] rd_val;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [9:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdv;
    int          stall;
    logic        clr;
    logic        hold;
    logic [31:0] exp_res;
    logic        exp_mis;
    logic        exp_ill;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  amo_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .kind_i       (kind_i),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .clear_rsv_i  (clear_rsv_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .misaligned_o (misaligned_o),
    .illegal_o    (illegal_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Read data appears only the cycle after a granted read.
  always @(posedge clk)
    mem_rdata_i <= (mem_req_o && mem_gnt_i && mem_we_o == 4'h0)
                 ? rd_val : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    vec_t e;
    int cyc, stall, nreq;
    logic wr, req_ok, seen;
    logic [31:0] wv;
    @(negedge clk);
    start_i = 1'b1; kind_i = v.kind; op_i = v.op;
    addr_i = v.addr; data_i = v.data; rd_val = v.rdv;
    clear_rsv_i = v.clr; mem_gnt_i = 1'b1;
    stall = v.stall;
    sb.push_back(v);
    cyc = 0; nreq = 0; wr = 1'b0; wv = '0;
    req_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (v.hold) begin
        addr_i = v.addr ^ 32'h40;
        data_i = ~v.data;
      end else start_i = 1'b0;
      if (mem_req_o) begin
        nreq++;
        if (mem_addr_o !== v.addr) req_ok = 1'b0;
        if (mem_we_o !== 4'h0 && mem_we_o !== 4'hF) req_ok = 1'b0;
        if (stall > 0) begin
          mem_gnt_i = 1'b0;
          stall--;
        end else mem_gnt_i = 1'b1;
        if (mem_gnt_i && mem_we_o == 4'hF) begin
          wr = 1'b1;
          wv = mem_wdata_o;
        end
      end else mem_gnt_i = 1'b1;
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0; clear_rsv_i = 1'b0; mem_gnt_i = 1'b1;
    e = sb.pop_front();
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done_o within %0d cycles", e.name, cyc);
      return;
    end
    chk({e.name, " latency"}, 32'(cyc), 32'(e.exp_lat));
    chk({e.name, " result"}, result_o, e.exp_res);
    chk({e.name, " misaligned"}, 32'(misaligned_o), 32'(e.exp_mis));
    chk({e.name, " illegal"}, 32'(illegal_o), 32'(e.exp_ill));
    chk({e.name, " wrote"}, 32'(wr), 32'(e.exp_wr));
    if (e.exp_wr) chk({e.name, " wdata"}, wv, e.exp_wdata);
    if (e.exp_lat == 1) chk({e.name, " no req"}, 32'(nreq), 32'd0);
    chk({e.name, " req stable"}, 32'(req_ok), 32'd1);
    @(negedge clk);
    chk({e.name, " done pulse"}, 32'(done_o), 32'd0);
    chk({e.name, " result hold"}, result_o, e.exp_res);
  endtask

  initial begin
    vec_t v;
    int n;
    logic got_done;
    vecs = '{
      '{"add_ovf", AMO_KIND_RMW, AMOADD, 32'h100, 32'h1, 32'h7FFFFFFF,
        0, 0, 0, 32'h7FFFFFFF, 0, 0, 4, 1, 32'h80000000},
      '{"min", AMO_KIND_RMW, AMOMIN, 32'h100, 32'h1, 32'hFFFFFFFF,
        0, 0, 0, 32'hFFFFFFFF, 0, 0, 4, 1, 32'hFFFFFFFF},
      '{"minu", AMO_KIND_RMW, AMOMINU, 32'h100, 32'h1, 32'hFFFFFFFF,
        0, 0, 0, 32'hFFFFFFFF, 0, 0, 4, 1, 32'h00000001},
      '{"max", AMO_KIND_RMW, AMOMAX, 32'h100, 32'h1, 32'hFFFFFFFF,
        0, 0, 0, 32'hFFFFFFFF, 0, 0, 4, 1, 32'h00000001},
      '{"maxu", AMO_KIND_RMW, AMOMAXU, 32'h100, 32'h1, 32'hFFFFFFFF,
        0, 0, 0, 32'hFFFFFFFF, 0, 0, 4, 1, 32'hFFFFFFFF},
      '{"swap", AMO_KIND_RMW, AMOSWAP, 32'h104, 32'hCAFEF00D,
        32'h12345678, 0, 0, 0, 32'h12345678, 0, 0, 4, 1, 32'hCAFEF00D},
      '{"xor", AMO_KIND_RMW, AMOXOR, 32'h108, 32'hFF00FF00, 32'hF0F0F0F0,
        0, 0, 0, 32'hF0F0F0F0, 0, 0, 4, 1, 32'h0FF00FF0},
      '{"and", AMO_KIND_RMW, AMOAND, 32'h108, 32'hFF00FF00, 32'hF0F0F0F0,
        0, 0, 0, 32'hF0F0F0F0, 0, 0, 4, 1, 32'hF000F000},
      '{"or", AMO_KIND_RMW, AMOOR, 32'h108, 32'hFF00FF00, 32'hF0F0F0F0,
        0, 0, 0, 32'hF0F0F0F0, 0, 0, 4, 1, 32'hFFF0FFF0},
      '{"lr", AMO_KIND_LR, AMONOP, 32'h200, 32'h0, 32'h55,
        0, 0, 0, 32'h55, 0, 0, 3, 0, 32'h0},
      '{"sc_ok", AMO_KIND_SC, AMONOP, 32'h200, 32'hAA, 32'h0,
        0, 0, 0, 32'h0, 0, 0, 2, 1, 32'hAA},
      '{"sc_again", AMO_KIND_SC, AMONOP, 32'h200, 32'hAA, 32'h0,
        0, 0, 0, 32'h1, 0, 0, 1, 0, 32'h0},
      '{"lr2", AMO_KIND_LR, AMONOP, 32'h200, 32'h0, 32'h77,
        0, 0, 0, 32'h77, 0, 0, 3, 0, 32'h0},
      '{"sc_addr", AMO_KIND_SC, AMONOP, 32'h204, 32'hBB, 32'h0,
        0, 0, 0, 32'h1, 0, 0, 1, 0, 32'h0},
      '{"misal", AMO_KIND_RMW, AMOADD, 32'h102, 32'h1, 32'h0,
        0, 0, 0, 32'h0, 1, 0, 1, 0, 32'h0},
      '{"nop", AMO_KIND_RMW, AMONOP, 32'h100, 32'h1, 32'h0,
        0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h0},
      '{"not1hot", AMO_KIND_RMW, 10'h003, 32'h100, 32'h1, 32'h0,
        0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h0},
      '{"stall_rd", AMO_KIND_RMW, AMOADD, 32'h300, 32'h6, 32'h5,
        3, 0, 0, 32'h5, 0, 0, 7, 1, 32'hB},
      '{"lr3", AMO_KIND_LR, AMONOP, 32'h400, 32'h0, 32'h9,
        0, 0, 0, 32'h9, 0, 0, 3, 0, 32'h0},
      '{"sc_stall", AMO_KIND_SC, AMONOP, 32'h400, 32'h1234, 32'h0,
        2, 0, 0, 32'h0, 0, 0, 4, 1, 32'h1234},
      '{"lr4", AMO_KIND_LR, AMONOP, 32'h500, 32'h0, 32'h3,
        0, 0, 0, 32'h3, 0, 0, 3, 0, 32'h0},
      '{"rmw_keep", AMO_KIND_RMW, AMOXOR, 32'h500, 32'h1, 32'h3,
        0, 0, 1, 32'h3, 0, 0, 4, 1, 32'h2},
      '{"sc_keep", AMO_KIND_SC, AMONOP, 32'h500, 32'h42, 32'h0,
        0, 0, 0, 32'h0, 0, 0, 2, 1, 32'h42},
      '{"lr_clr", AMO_KIND_LR, AMONOP, 32'h600, 32'h0, 32'h8,
        0, 1, 0, 32'h8, 0, 0, 3, 0, 32'h0},
      '{"sc_clr", AMO_KIND_SC, AMONOP, 32'h600, 32'h5, 32'h0,
        0, 0, 0, 32'h1, 0, 0, 1, 0, 32'h0}
    };

    reset = 1'b1; start_i = 1'b0; kind_i = '0; op_i = '0;
    addr_i = '0; data_i = '0; clear_rsv_i = 1'b0;
    mem_gnt_i = 1'b1; rd_val = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    chk("rst flags", 32'({misaligned_o, illegal_o}), 32'd0);
    chk("rst req", 32'({mem_req_o, mem_we_o}), 32'd0);
    chk("rst addr", mem_addr_o, 32'd0);
    chk("rst wdata", mem_wdata_o, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Standalone clear pulse between LR and SC.
    v = vecs[9];
    do_op(v);
    @(negedge clk); clear_rsv_i = 1'b1;
    @(negedge clk); clear_rsv_i = 1'b0;
    v = vecs[11];
    v.name = "sc_after_pulse";
    do_op(v);

    // Reset while a write is pending: abandon, drop reservation.
    v = vecs[9];
    v.name = "lr_pre_rst";
    v.addr = 32'h700;
    do_op(v);
    @(negedge clk);
    start_i = 1'b1; kind_i = AMO_KIND_RMW; op_i = AMOADD;
    addr_i = 32'h700; data_i = 32'h1; rd_val = 32'h10;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(mem_req_o && mem_we_o == 4'hF) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wr reached write", 32'(mem_we_o), 32'hF);
    mem_gnt_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wr req", 32'(mem_req_o), 32'd0);
    chk("rst_wr busy", 32'(busy_o), 32'd0);
    chk("rst_wr result", result_o, 32'd0);
    reset = 1'b0; mem_gnt_i = 1'b1;
    got_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || mem_req_o) got_done = 1'b1;
    end
    chk("rst_wr no done", 32'(got_done), 32'd0);
    v = vecs[11];
    v.name = "sc_after_rst";
    v.addr = 32'h700;
    do_op(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
